cwc_capture_ctrl: RTL and testbench

//  Sequences one ChipWatcher capture into the sample RAM: arm, pre-trigger

---
 rtl/cwc_capture_if.sv | 41 ++++
 rtl/cwc_capture_ctrl.sv | 162 ++++++++++++++++
 tb/tb_cwc_capture_ctrl.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/cwc_capture_if.sv
// Capture controller bus: arm/config from the host, sample RAM write port and status back.
// CWC_CAPTURE_TRIG_EDGE_EN adds the per-bit trig_edge select.
interface cwc_capture_if #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
);
  logic              arm;
  logic              abort;
  logic [DATA_W-1:0] probe_data;
  logic [DATA_W-1:0] trig_mask;
  logic [DATA_W-1:0] trig_value;
`ifdef CWC_CAPTURE_TRIG_EDGE_EN
  logic [DATA_W-1:0] trig_edge;
`endif
  logic [ADDR_W-1:0] pre_cnt;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [DATA_W-1:0] ram_wdata;
  logic              busy;
  logic              triggered;
  logic              done;
  logic [ADDR_W-1:0] trig_addr;
  logic [ADDR_W-1:0] start_addr;

  modport master (
`ifdef CWC_CAPTURE_TRIG_EDGE_EN
    output trig_edge,
`endif
    output arm, abort, probe_data, trig_mask, trig_value, pre_cnt,
    input  ram_we, ram_waddr, ram_wdata, busy, triggered, done, trig_addr, start_addr
  );

  modport slave (
`ifdef CWC_CAPTURE_TRIG_EDGE_EN
    input  trig_edge,
`endif
    input  arm, abort, probe_data, trig_mask, trig_value, pre_cnt,
    output ram_we, ram_waddr, ram_wdata, busy, triggered, done, trig_addr, start_addr
  );
endinterface

// File: rtl/cwc_capture_ctrl.sv
// ChipWatcher capture sequencer: pre-trigger fill, circular trigger wait, post count.
// Optional edge-qualified trigger bits when CWC_CAPTURE_TRIG_EDGE_EN is defined.
//
// state  | meaning
// S_IDLE | no capture, all outputs 0, waiting for arm
// S_PRE  | writing the pre-trigger samples, trigger ignored
// S_WAIT | circular writes, comparing every sample against the trigger
// S_POST | writing the remaining DEPTH-1-pre samples after the trigger
// S_DONE | capture complete, done held until arm/abort/rst
module cwc_capture_ctrl #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 1024,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  cwc_capture_if.slave cap
);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] pre_q;
  logic [ADDR_W-1:0] wptr_q;
  logic [DATA_W-1:0] mask_q;
  logic [DATA_W-1:0] value_q;
  logic              we_q;
  logic [ADDR_W-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              trig_q;
  logic              done_q;
  logic [ADDR_W-1:0] trig_addr_q;
  logic [ADDR_W-1:0] start_addr_q;
  logic              sampling;
  logic              match;
  logic [ADDR_W-1:0] post_len;

  assign sampling = (state_q == S_PRE) || (state_q == S_WAIT) || (state_q == S_POST);
  assign post_len = MAX_ADDR - pre_q;

`ifdef CWC_CAPTURE_TRIG_EDGE_EN
  logic [DATA_W-1:0] edge_q;
  logic [DATA_W-1:0] prev_q;
  logic              prev_vld_q;
  logic [DATA_W-1:0] edge_sel;

  // Edge bits need a real previous sample; right after arm there is none.
  assign edge_sel = edge_q & mask_q;
  assign match = (((cap.probe_data ^ value_q) & mask_q) == '0)
              && (((~(prev_q ^ cap.probe_data)) & edge_sel) == '0)
              && (prev_vld_q || (edge_sel == '0));
`else
  assign match = ((cap.probe_data ^ value_q) & mask_q) == '0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (cap.arm) state_d = (cap.pre_cnt == '0) ? S_WAIT : S_PRE;
      S_PRE:          if (cnt_q == ONE) state_d = S_WAIT;
      S_WAIT:         if (match) state_d = (post_len == '0) ? S_DONE : S_POST;
      S_POST:         if (cnt_q == ONE) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
    if (cap.abort) state_d = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      pre_q        <= '0;
      wptr_q       <= '0;
      mask_q       <= '0;
      value_q      <= '0;
      we_q         <= 1'b0;
      waddr_q      <= '0;
      wdata_q      <= '0;
      trig_q       <= 1'b0;
      done_q       <= 1'b0;
      trig_addr_q  <= '0;
      start_addr_q <= '0;
`ifdef CWC_CAPTURE_TRIG_EDGE_EN
      edge_q       <= '0;
      prev_q       <= '0;
      prev_vld_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (cap.abort) begin
        we_q         <= 1'b0;
        waddr_q      <= '0;
        wdata_q      <= '0;
        wptr_q       <= '0;
        trig_q       <= 1'b0;
        done_q       <= 1'b0;
        trig_addr_q  <= '0;
        start_addr_q <= '0;
      end else begin
        we_q <= sampling;
        if (sampling) begin
          wdata_q <= cap.probe_data;
          waddr_q <= wptr_q;
          wptr_q  <= wptr_q + ONE;
`ifdef CWC_CAPTURE_TRIG_EDGE_EN
          prev_q     <= cap.probe_data;
          prev_vld_q <= 1'b1;
`endif
        end
        case (state_q)
          S_IDLE, S_DONE: begin
            if (cap.arm) begin
              // An ADDR_W-wide pre_cnt can never exceed DEPTH-1, so no clamp logic is needed.
              pre_q        <= cap.pre_cnt;
              cnt_q        <= cap.pre_cnt;
              mask_q       <= cap.trig_mask;
              value_q      <= cap.trig_value;
              wptr_q       <= '0;
              trig_q       <= 1'b0;
              done_q       <= 1'b0;
              trig_addr_q  <= '0;
              start_addr_q <= '0;
`ifdef CWC_CAPTURE_TRIG_EDGE_EN
              edge_q       <= cap.trig_edge;
              prev_vld_q   <= 1'b0;
`endif
            end
          end
          S_PRE: cnt_q <= cnt_q - ONE;
          S_WAIT: begin
            if (match) begin
              trig_addr_q  <= wptr_q;
              start_addr_q <= wptr_q - pre_q;
              cnt_q        <= post_len;
              trig_q       <= 1'b1;
              if (post_len == '0) done_q <= 1'b1;
            end
          end
          S_POST: begin
            cnt_q <= cnt_q - ONE;
            if (cnt_q == ONE) done_q <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign cap.ram_we     = we_q;
  assign cap.ram_waddr  = waddr_q;
  assign cap.ram_wdata  = wdata_q;
  assign cap.busy       = sampling;
  assign cap.triggered  = trig_q;
  assign cap.done       = done_q;
  assign cap.trig_addr  = trig_addr_q;
  assign cap.start_addr = start_addr_q;

endmodule

// File: tb/tb_cwc_capture_ctrl.sv
// Scoreboard bench for cwc_capture_ctrl at DEPTH=16, DATA_W=8; expected RAM writes and
// completion addresses are queued by the stimulus and checked by independent monitors.
module tb_cwc_capture_ctrl;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cwc_capture_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) cap ();
  cwc_capture_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .cap(cap));

  int n_chk  = 0;
  int n_fail = 0;
  logic [11:0] wr_q[$];
  logic [7:0]  done_q[$];
  logic        done_d = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // RAM write monitor: every presented write must be the next queued one.
  always @(negedge clk) begin
    logic [11:0] exp_w;
    if (cap.ram_we === 1'b1) begin
      n_chk++;
      if (wr_q.size() == 0) begin
        n_fail++;
        $display("FAIL write_extra: addr %0h data %0h, no write expected", cap.ram_waddr, cap.ram_wdata);
      end else begin
        exp_w = wr_q.pop_front();
        if ({cap.ram_waddr, cap.ram_wdata} !== exp_w) begin
          n_fail++;
          $display("FAIL write: got addr %0h data %0h, expected addr %0h data %0h",
                   cap.ram_waddr, cap.ram_wdata, exp_w[11:8], exp_w[7:0]);
        end
      end
    end
  end

  // Completion monitor: on each rising done, trig/start addresses must match the queue.
  always @(negedge clk) begin
    logic [7:0] exp_d;
    if (cap.done === 1'b1 && done_d !== 1'b1) begin
      n_chk++;
      if (done_q.size() == 0) begin
        n_fail++;
        $display("FAIL done_extra: trig_addr %0h start_addr %0h, no completion expected",
                 cap.trig_addr, cap.start_addr);
      end else begin
        exp_d = done_q.pop_front();
        if ({cap.trig_addr, cap.start_addr} !== exp_d) begin
          n_fail++;
          $display("FAIL done_addr: got trig %0h start %0h, expected trig %0h start %0h",
                   cap.trig_addr, cap.start_addr, exp_d[7:4], exp_d[3:0]);
        end
      end
    end
    done_d = cap.done;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_arm(input logic [3:0] pre, input logic [7:0] mask, input logic [7:0] value);
    cap.arm        = 1'b1;
    cap.pre_cnt    = pre;
    cap.trig_mask  = mask;
    cap.trig_value = value;
    tick();
    cap.arm = 1'b0;
  endtask

  task automatic put(input logic [7:0] d, input logic [3:0] addr);
    cap.probe_data = d;
    wr_q.push_back({addr, d});
    tick();
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_ram_we"},     32'(cap.ram_we),     0);
    check({tag, "_busy"},       32'(cap.busy),       0);
    check({tag, "_triggered"},  32'(cap.triggered),  0);
    check({tag, "_done"},       32'(cap.done),       0);
    check({tag, "_trig_addr"},  32'(cap.trig_addr),  0);
    check({tag, "_start_addr"}, 32'(cap.start_addr), 0);
  endtask

  initial begin
    logic [7:0] d;
    cap.arm        = 1'b0;
    cap.abort      = 1'b0;
    cap.probe_data = '0;
    cap.trig_mask  = '0;
    cap.trig_value = '0;
    cap.pre_cnt    = '0;
`ifdef CWC_CAPTURE_TRIG_EDGE_EN
    cap.trig_edge  = '0;
`endif
    rst = 1'b1;
    tick();
    tick();
    check_idle("reset");
    check("reset_waddr", 32'(cap.ram_waddr), 0);
    check("reset_wdata", 32'(cap.ram_wdata), 0);
    rst = 1'b0;
    tick();

    // Ramp, pre=4, trigger on A5: sample 165 lands at address 5, 11 post writes.
    done_q.push_back({4'd5, 4'd1});
    do_arm(4'd4, 8'hFF, 8'hA5);
    check("t1_busy_after_arm", 32'(cap.busy), 1);
    for (int i = 0; i < 177; i++) begin
      put(i[7:0], i[3:0]);
      if (i == 164) check("t1_not_trig_yet", 32'(cap.triggered), 0);
      if (i == 165) begin
        check("t1_triggered", 32'(cap.triggered), 1);
        check("t1_trig_addr", 32'(cap.trig_addr), 5);
        check("t1_start_addr", 32'(cap.start_addr), 1);
      end
      if (i == 175) check("t1_done_early", 32'(cap.done), 0);
    end
    check("t1_done", 32'(cap.done), 1);
    check("t1_busy_end", 32'(cap.busy), 0);
    tick();
    check("t1_we_off", 32'(cap.ram_we), 0);
    check("t1_done_held", 32'(cap.done), 1);
    check("t1_writes_drained", 32'(wr_q.size()), 0);

    // Re-arm from DONE, pre=0, mask=0: triggers on the first WAIT sample.
    done_q.push_back({4'd0, 4'd0});
    do_arm(4'd0, 8'h00, 8'h00);
    check("t2_trig_cleared", 32'(cap.triggered), 0);
    check("t2_done_cleared", 32'(cap.done), 0);
    for (int i = 0; i < 16; i++) begin
      put(8'(8'h30 + i), i[3:0]);
      if (i == 0) check("t2_trig_first", 32'(cap.triggered), 1);
      if (i == 14) check("t2_done_early", 32'(cap.done), 0);
    end
    check("t2_done", 32'(cap.done), 1);
    tick();
    check("t2_writes_drained", 32'(wr_q.size()), 0);

    // Largest pre count (15): the A5 at sample 2 is in PRE, the one at 17 triggers, post=0.
    done_q.push_back({4'd1, 4'd2});
    do_arm(4'd15, 8'hFF, 8'hA5);
    for (int i = 0; i < 18; i++) begin
      d = (i == 2 || i == 17) ? 8'hA5 : 8'(i);
      put(d, i[3:0]);
      if (i == 16) check("t3_pre_match_ignored", 32'(cap.triggered), 0);
    end
    check("t3_triggered", 32'(cap.triggered), 1);
    check("t3_done", 32'(cap.done), 1);
    tick();
    check("t3_writes_drained", 32'(wr_q.size()), 0);

    // Abort in POST with simultaneous arm: abort wins.
    do_arm(4'd2, 8'hFF, 8'h03);
    for (int i = 0; i < 6; i++) put(i[7:0], i[3:0]);
    check("t4_busy_post", 32'(cap.busy), 1);
    check("t4_trig_post", 32'(cap.triggered), 1);
    cap.abort      = 1'b1;
    cap.arm        = 1'b1;
    cap.probe_data = 8'h66;
    tick();
    cap.abort = 1'b0;
    cap.arm   = 1'b0;
    check_idle("t4_abort");
    tick();
    check("t4_still_idle", 32'(cap.busy), 0);
    check("t4_writes_drained", 32'(wr_q.size()), 0);

    // New arm after abort restarts at address 0.
    done_q.push_back({4'd0, 4'd0});
    do_arm(4'd0, 8'h00, 8'h00);
    for (int i = 0; i < 16; i++) put(8'(8'hC0 + i), i[3:0]);
    check("t4b_done", 32'(cap.done), 1);
    tick();

    // Arm during WAIT is ignored; waddr wraps; rst in POST clears everything.
    do_arm(4'd1, 8'hFF, 8'h77);
    for (int i = 0; i < 26; i++) begin
      if (i == 10) begin
        cap.arm     = 1'b1;
        cap.pre_cnt = 4'd5;
      end
      d = (i == 20) ? 8'h77 : 8'(i);
      put(d, i[3:0]);
      cap.arm = 1'b0;
      if (i == 10) check("t5_busy_after_rearm", 32'(cap.busy), 1);
      if (i == 20) begin
        check("t5_trig_addr", 32'(cap.trig_addr), 4);
        check("t5_start_addr", 32'(cap.start_addr), 3);
      end
    end
    rst            = 1'b1;
    cap.probe_data = 8'h99;
    tick();
    rst = 1'b0;
    check_idle("t5_rst");
    check("t5_rst_waddr", 32'(cap.ram_waddr), 0);
    check("t5_rst_wdata", 32'(cap.ram_wdata), 0);
    tick();
    check("t5_writes_drained", 32'(wr_q.size()), 0);

`ifdef CWC_CAPTURE_TRIG_EDGE_EN
    // Bit0 held high, then 0 -> 1: only the rising sample 31 triggers.
    cap.trig_edge = 8'h01;
    done_q.push_back({4'd15, 4'd15});
    do_arm(4'd0, 8'h01, 8'h01);
    for (int i = 0; i < 47; i++) begin
      d = (i == 30) ? 8'h00 : 8'h01;
      put(d, i[3:0]);
      if (i == 0)  check("te_first_wait_no_edge", 32'(cap.triggered), 0);
      if (i == 30) check("te_level_hold_no_trig", 32'(cap.triggered), 0);
      if (i == 31) check("te_rise_trig_addr", 32'({cap.triggered, cap.trig_addr}), 32'h1F);
    end
    check("te_done", 32'(cap.done), 1);
    tick();
    check("te_writes_drained", 32'(wr_q.size()), 0);
    cap.trig_edge = 8'h00;
`endif

    tick();
    check("done_queue_drained", 32'(done_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
